// File: rtl/event_ring_buffers.sv
// N-buffer event store: a 16-bit writer fills buffers in ring order and 32-bit readout drains them
// in the same order, with a two-step clear handshake, occupancy tracking and a sticky overflow flag.
module event_ring_buffers #(
   parameter int unsigned NBUF           = 4,
   parameter int unsigned WR_ADDR_BITS   = 7,
   parameter bit          CLEAR_TWO_STEP = 1'b1
) (
   input  logic                    clk33_i,
   input  logic                    rst_n_i,
   input  logic [WR_ADDR_BITS-1:0] event_wr_addr_i,
   input  logic [15:0]             event_wr_dat_i,
   input  logic                    event_wr_i,
   input  logic                    event_done_i,
   input  logic [WR_ADDR_BITS-2:0] event_rd_addr_i,
   output logic [31:0]             event_rd_dat_o,
   input  logic                    clear_evt_i,
   output logic                    clear_done_o,
   output logic [2:0]              read_buffer_o,
   output logic [2:0]              write_buffer_o,
   output logic [NBUF-1:0]         buffer_active_o,
   output logic [3:0]              count_o,
   output logic                    full_o,
   output logic                    empty_o,
   output logic                    overflow_o,
   output logic [31:0]             status_o
);

   localparam int unsigned PTR_W  = $clog2(NBUF);
   localparam int unsigned MEM_AW = PTR_W + WR_ADDR_BITS;
   localparam int unsigned DEPTH  = 2 ** MEM_AW;

   logic [15:0]      mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_n, wr_ptr_n;
   logic [3:0]       count, count_n;
   logic [NBUF-1:0]  active, active_n;
   logic             pending, pending_n;
   logic             fire, fire_n;
   logic             overflow;
   logic             fire_ok, done_ok;
   logic             full, empty;
   logic [2:0]       rd_buf_q;
   logic             clear_done_q;
   logic [31:0]      rd_dat_q;

   assign full  = (count == 4'(NBUF));
   assign empty = (count == 4'd0);

   // Writes into a buffer still held by readout (ring full) are dropped.
   always_ff @(posedge clk33_i) begin
      if (rst_n_i && event_wr_i && !full) begin
         mem[{wr_ptr, event_wr_addr_i}] <= event_wr_dat_i;
      end
   end

   // Registered 32-bit read; even word in the low half.
   always_ff @(posedge clk33_i) begin
      if (!rst_n_i) begin
         rd_dat_q <= 32'h0;
      end else begin
         rd_dat_q <= {mem[{rd_ptr, event_rd_addr_i, 1'b1}], mem[{rd_ptr, event_rd_addr_i, 1'b0}]};
      end
   end

   // Clear request decode: fire is the registered release strobe.
   always_comb begin
      pending_n = 1'b0;
      fire_n    = 1'b0;
      if (CLEAR_TWO_STEP) begin
         pending_n = pending;
         if (clear_evt_i) begin
            pending_n = !pending;
            fire_n    = pending;
         end
      end else begin
         fire_n = clear_evt_i;
      end
   end

   // Ring bookkeeping; applying done after clear lets the set win when both hit one buffer.
   always_comb begin
      fire_ok  = fire && !empty;
      done_ok  = event_done_i && (!full || fire_ok);
      active_n = active;
      rd_ptr_n = rd_ptr;
      wr_ptr_n = wr_ptr;
      count_n  = count;
      if (fire_ok) begin
         active_n[rd_ptr] = 1'b0;
         rd_ptr_n         = rd_ptr + PTR_W'(1);
      end
      if (done_ok) begin
         active_n[wr_ptr] = 1'b1;
         wr_ptr_n         = wr_ptr + PTR_W'(1);
      end
      case ({done_ok, fire_ok})
         2'b10:   count_n = count + 4'd1;
         2'b01:   count_n = count - 4'd1;
         default: count_n = count;
      endcase
   end

   always_ff @(posedge clk33_i) begin
      if (!rst_n_i) begin
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         count        <= 4'd0;
         active       <= '0;
         pending      <= 1'b0;
         fire         <= 1'b0;
         overflow     <= 1'b0;
         clear_done_q <= 1'b0;
         rd_buf_q     <= 3'd0;
      end else begin
         rd_ptr       <= rd_ptr_n;
         wr_ptr       <= wr_ptr_n;
         count        <= count_n;
         active       <= active_n;
         pending      <= pending_n;
         fire         <= fire_n;
         overflow     <= overflow || (event_done_i && !done_ok);
         clear_done_q <= fire_ok;
         rd_buf_q     <= 3'(rd_ptr);
      end
   end

   assign event_rd_dat_o  = rd_dat_q;
   assign clear_done_o    = clear_done_q;
   assign read_buffer_o   = rd_buf_q;
   assign write_buffer_o  = 3'(wr_ptr);
   assign buffer_active_o = active;
   assign count_o         = count;
   assign full_o          = full;
   assign empty_o         = empty;
   assign overflow_o      = overflow;
   assign status_o        = {8'h00, 8'(active), 1'b0, active[rd_ptr], overflow, empty, full,
                             count, 3'(wr_ptr), 3'(rd_ptr), pending};

endmodule
